// File: rtl/rf_writeback_arbiter.sv
// rf_writeback_arbiter
//   Shares the register file's single write port among NUM_REQ writeback
//   sources using a round-robin arbiter. At most one request is granted per
//   cycle. The winner's address and data are captured into an output register
//   that drives the register file write port one cycle after the transfer.
//
// Ports
//   clk, reset_n     clock, asynchronous active-low reset
//   req_valid        per-requester write request
//   req_addr         flattened addresses, requester i at slice i
//   req_data         flattened data, requester i at slice i
//   req_ready        one-hot-or-zero grant (combinational)
//   stall            pipeline hold, blocks all grants
//   write_en/addr/data  registered write to the register file
//   perf_clr         synchronous clear of the stall counters
//   perf_stall_cnt   flattened per-requester stall counters
//
// Build option
//   RF_WB_PERF_EN    when defined, builds saturating per-requester stall
//                    counters. Otherwise perf_stall_cnt is tied to 0 and
//                    perf_clr is ignored. The ports exist in both builds.

module rf_writeback_arbiter #(
   parameter int NUM_REQ       = 3,
   parameter int LOG2_NUM_REGS = 4,
   parameter int MACHINE_WIDTH = 32,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic [NUM_REQ-1:0]                 req_valid,
   input  logic [NUM_REQ*LOG2_NUM_REGS-1:0]   req_addr,
   input  logic [NUM_REQ*MACHINE_WIDTH-1:0]   req_data,
   output logic [NUM_REQ-1:0]                 req_ready,
   input  logic                               stall,
   output logic                               write_en,
   output logic [LOG2_NUM_REGS-1:0]           write_addr,
   output logic [MACHINE_WIDTH-1:0]           write_data,
   input  logic                               perf_clr,
   output logic [NUM_REQ*CNT_WIDTH-1:0]       perf_stall_cnt
);

   localparam int PTR_W = $clog2(NUM_REQ);

   logic [PTR_W-1:0]         rr_ptr;
   logic [PTR_W-1:0]         win_idx;
   logic [PTR_W-1:0]         next_ptr;
   logic                     win_any;
   logic                     grant;
   logic [LOG2_NUM_REGS-1:0] sel_addr;
   logic [MACHINE_WIDTH-1:0] sel_data;

   // Scan requesters starting at rr_ptr; the first valid one wins.
   always_comb begin
      int         idx;
      logic [PTR_W-1:0] idx_w;
      idx     = 0;
      idx_w   = '0;
      win_any = 1'b0;
      win_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx   = (int'(rr_ptr) + k) % NUM_REQ;
         idx_w = PTR_W'(idx);
         if (!win_any && req_valid[idx_w]) begin
            win_any = 1'b1;
            win_idx = idx_w;
         end
      end
   end

   // Ready is suppressed during reset, so nothing looks accepted while the
   // output register is being cleared.
   assign grant = win_any & ~stall & reset_n;

   always_comb begin
      req_ready = '0;
      if (grant) begin
         req_ready[win_idx] = 1'b1;
      end
   end

   always_comb begin
      if (win_idx == PTR_W'(NUM_REQ - 1)) begin
         next_ptr = '0;
      end else begin
         next_ptr = win_idx + 1'b1;
      end
   end

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_idx == PTR_W'(i)) begin
            sel_addr = req_addr[i*LOG2_NUM_REGS +: LOG2_NUM_REGS];
            sel_data = req_data[i*MACHINE_WIDTH +: MACHINE_WIDTH];
         end
      end
   end

   // A grant is only given to a valid requester, so grant equals transfer.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr     <= '0;
         write_en   <= 1'b0;
         write_addr <= '0;
         write_data <= '0;
      end else if (grant) begin
         rr_ptr     <= next_ptr;
         write_en   <= 1'b1;
         write_addr <= sel_addr;
         write_data <= sel_data;
      end else begin
         write_en   <= 1'b0;
      end
   end

`ifdef RF_WB_PERF_EN
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_perf
      logic [CNT_WIDTH-1:0] cnt;

      // Clear wins over increment; the counter sticks at all-ones.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            cnt <= '0;
         end else if (perf_clr) begin
            cnt <= '0;
         end else if (req_valid[i] && !req_ready[i] && (cnt != {CNT_WIDTH{1'b1}})) begin
            cnt <= cnt + 1'b1;
         end
      end

      assign perf_stall_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt;
   end
`else
   logic unused_perf_clr;
   assign unused_perf_clr = perf_clr;
   assign perf_stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
module tb_rf_writeback_arbiter;

   localparam int NR = 3;
   localparam int LW = 4;
   localparam int MW = 32;
   localparam int CW = 4;

   logic              clk;
   logic              reset_n;
   logic [NR-1:0]     req_valid;
   logic [NR*LW-1:0]  req_addr;
   logic [NR*MW-1:0]  req_data;
   logic [NR-1:0]     req_ready;
   logic              stall;
   logic              write_en;
   logic [LW-1:0]     write_addr;
   logic [MW-1:0]     write_data;
   logic              perf_clr;
   logic [NR*CW-1:0]  perf_stall_cnt;

   typedef struct packed {
      logic [LW-1:0] addr;
      logic [MW-1:0] data;
   } wb_t;

   wb_t           exp_q[$];
   logic [MW-1:0] rf [0:(1<<LW)-1];

   int checks = 0;
   int errors = 0;

   rf_writeback_arbiter #(
      .NUM_REQ(NR), .LOG2_NUM_REGS(LW), .MACHINE_WIDTH(MW), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
      .req_ready(req_ready), .stall(stall),
      .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
      .perf_clr(perf_clr), .perf_stall_cnt(perf_stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: every write presented to the register file must match the
   // oldest expected write; it also updates the register-file model.
   initial begin
      wb_t e;
      forever begin
         @(negedge clk);
         if (reset_n && write_en) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none at %0t",
                        write_addr, write_data, $time);
            end else begin
               e = exp_q.pop_front();
               check("wb_addr", 64'(write_addr), 64'(e.addr));
               check("wb_data", 64'(write_data), 64'(e.data));
            end
            rf[write_addr] = write_data;
         end
      end
   end

   task automatic set_req(input int i, input logic [LW-1:0] a, input logic [MW-1:0] d);
      req_addr[i*LW +: LW] = a;
      req_data[i*MW +: MW] = d;
   endtask

   // One cycle of stimulus: drive, check the combinational grant, push the
   // expected write for the hand-computed winner, advance to posedge+1.
   task automatic cyc(input logic [NR-1:0] v, input logic st,
                      input logic [NR-1:0] exp_rdy, input string nm);
      wb_t e;
      req_valid = v;
      stall     = st;
      #1;
      check(nm, 64'(req_ready), 64'(exp_rdy));
      for (int i = 0; i < NR; i++) begin
         if (exp_rdy[i]) begin
            e.addr = req_addr[i*LW +: LW];
            e.data = req_data[i*MW +: MW];
            exp_q.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n   = 1'b0;
      req_valid = 3'b111;
      stall     = 1'b0;
      #1;
      check("rst_ready", 64'(req_ready), 64'(0));
      check("rst_we", 64'(write_en), 64'(0));
      check("rst_addr", 64'(write_addr), 64'(0));
      check("rst_data", 64'(write_data), 64'(0));
      check("rst_perf", 64'(perf_stall_cnt), 64'(0));
      req_valid = '0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n   = 1'b0;
      req_valid = '0;
      req_addr  = '0;
      req_data  = '0;
      stall     = 1'b0;
      perf_clr  = 1'b0;
      for (int i = 0; i < (1<<LW); i++) rf[i] = '0;
      @(posedge clk);
      #1;

      // Single requester
      do_reset();
      set_req(0, 4'd5, 32'hA5A5);
      cyc(3'b001, 1'b0, 3'b001, "single_ready");
      check("single_we", 64'(write_en), 64'(1));
      cyc(3'b000, 1'b0, 3'b000, "single_idle");
      check("single_we_drop", 64'(write_en), 64'(0));
      check("single_rf5", 64'(rf[5]), 64'(32'hA5A5));

      // Fairness
      do_reset();
      set_req(0, 4'd1, 32'h10);
      set_req(1, 4'd2, 32'h20);
      set_req(2, 4'd3, 32'h30);
      for (int r = 0; r < 2; r++) begin
         cyc(3'b111, 1'b0, 3'b001, "fair_g0");
         cyc(3'b111, 1'b0, 3'b010, "fair_g1");
         cyc(3'b111, 1'b0, 3'b100, "fair_g2");
      end
      cyc(3'b000, 1'b0, 3'b000, "fair_idle");

      // Stall: rr_ptr moves to 1 first, then must hold through the stall
      do_reset();
      set_req(0, 4'd4, 32'h40);
      cyc(3'b001, 1'b0, 3'b001, "stall_pre_g0");
      set_req(1, 4'd9, 32'h99);
      for (int s = 0; s < 3; s++) begin
         cyc(3'b010, 1'b1, 3'b000, "stall_ready");
         check("stall_we", 64'(write_en), 64'(0));
      end
`ifdef RF_WB_PERF_EN
      check("stall_cnt1", 64'(perf_stall_cnt[1*CW +: CW]), 64'(3));
`else
      check("stall_cnt_off", 64'(perf_stall_cnt), 64'(0));
`endif
      cyc(3'b010, 1'b0, 3'b010, "stall_release");
`ifdef RF_WB_PERF_EN
      check("stall_cnt1_hold", 64'(perf_stall_cnt[1*CW +: CW]), 64'(3));
`endif
      set_req(2, 4'd6, 32'h66);
      cyc(3'b111, 1'b0, 3'b100, "post_stall_g2");
      cyc(3'b111, 1'b0, 3'b001, "post_stall_g0");
      cyc(3'b111, 1'b0, 3'b010, "post_stall_g1");
      cyc(3'b000, 1'b0, 3'b000, "post_stall_idle");

      // Same address: later grant wins in the register file
      do_reset();
      set_req(0, 4'd7, 32'h11);
      set_req(2, 4'd7, 32'h22);
      cyc(3'b101, 1'b0, 3'b001, "same_g0");
      cyc(3'b100, 1'b0, 3'b100, "same_g2");
      cyc(3'b000, 1'b0, 3'b000, "same_idle");
      check("same_rf7", 64'(rf[7]), 64'(32'h22));

      // Reset mid-stream: the write in the output register is dropped
      do_reset();
      set_req(0, 4'd1, 32'h10);
      set_req(1, 4'd2, 32'h20);
      set_req(2, 4'd3, 32'h30);
      cyc(3'b111, 1'b0, 3'b001, "mid_g0");
      req_valid = 3'b111;
      #1;
      check("mid_g1", 64'(req_ready), 64'(3'b010));
      @(posedge clk);
      #1;
      check("mid_we_pre", 64'(write_en), 64'(1));
      reset_n = 1'b0;
      #1;
      check("mid_rst_we", 64'(write_en), 64'(0));
      check("mid_rst_addr", 64'(write_addr), 64'(0));
      check("mid_rst_data", 64'(write_data), 64'(0));
      check("mid_rst_ready", 64'(req_ready), 64'(0));
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      cyc(3'b111, 1'b0, 3'b001, "mid_post_g0");
      cyc(3'b000, 1'b0, 3'b000, "mid_idle");

`ifdef RF_WB_PERF_EN
      // Saturation and clear
      do_reset();
      set_req(2, 4'd8, 32'h88);
      for (int s = 0; s < 20; s++) cyc(3'b100, 1'b1, 3'b000, "sat_ready");
      check("sat_cnt2", 64'(perf_stall_cnt[2*CW +: CW]), 64'(15));
      perf_clr = 1'b1;
      cyc(3'b100, 1'b1, 3'b000, "clr_ready");
      perf_clr = 1'b0;
      check("clr_cnt2", 64'(perf_stall_cnt[2*CW +: CW]), 64'(0));
      cyc(3'b100, 1'b1, 3'b000, "after_clr_ready");
      check("after_clr_cnt2", 64'(perf_stall_cnt[2*CW +: CW]), 64'(1));
      cyc(3'b000, 1'b0, 3'b000, "sat_idle");
`else
      perf_clr = 1'b1;
      cyc(3'b100, 1'b1, 3'b000, "clr_off_ready");
      perf_clr = 1'b0;
      check("clr_off_cnt", 64'(perf_stall_cnt), 64'(0));
      cyc(3'b000, 1'b0, 3'b000, "clr_off_idle");
`endif

      @(posedge clk);
      #1;
      check("scoreboard_drain", 64'(exp_q.size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rf_writeback_arbiter.md
# rf_writeback_arbiter

Round-robin arbiter that shares the register file's single write port among several writeback requesters (ALU, LSU, predicate unit) of the Harmonica SIMD pipeline. It accepts requests over a valid/ready handshake and grants at most one per cycle. The granted address and data go into an output register that drives the register file's `write_en`/`write_addr`/`write_data`. It sits between the execute-stage writeback sources and the GPR or predicate register file instance.

## Interface
Parameters:
- `NUM_REQ`, 3, number of writeback requesters (2..8).
- `LOG2_NUM_REGS`, 4, register address width; matches the register file.
- `MACHINE_WIDTH`, 32, data width; matches the register file.
- `CNT_WIDTH`, 16, width of each stall counter (used only with `RF_WB_PERF_EN`).

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester write request.
- `req_addr`  in  NUM_REQ*LOG2_NUM_REGS  flattened addresses; requester i at slice i.
- `req_data`  in  NUM_REQ*MACHINE_WIDTH  flattened data; requester i at slice i.
- `req_ready`  out  NUM_REQ  one-hot-or-zero grant (combinational).
- `stall`  in  1  pipeline hold; blocks all grants.
- `write_en`  out  1  to register file `write_en`.
- `write_addr`  out  LOG2_NUM_REGS  to register file `write_addr`.
- `write_data`  out  MACHINE_WIDTH  to register file `write_data`.
- `perf_clr`  in  1  synchronous clear of stall counters.
- `perf_stall_cnt`  out  NUM_REQ*CNT_WIDTH  per-requester stall counters.

## Operation
- **State:**
  - Round-robin pointer `rr_ptr` (0..NUM_REQ-1).
  - Output register (`write_en`, `write_addr`, `write_data`).
  - Optional counters.
- **Arbitration:**
  - Priority order is `rr_ptr`, `rr_ptr+1`, … modulo NUM_REQ.
  - The first requester in that order with `req_valid` high is winner w.
  - `req_ready[w]=1`; all other bits are 0.
  - If `stall=1` or no valid request, `req_ready=0`.
- **Transfer:** occurs for requester i when `req_valid[i] & req_ready[i]` at a posedge.
- **On transfer:**
  - `write_en<=1`, `write_addr<=req_addr[w]`, `write_data<=req_data[w]`.
  - `rr_ptr <= (w+1) mod NUM_REQ`.
- **No transfer:**
  - `write_en<=0`.
  - `write_addr`/`write_data` hold their values.
  - `rr_ptr` holds.
- **Requester rules:**
  - A requester holds valid/addr/data stable until it receives ready.
  - The arbiter does not check this.
- **Same-address requests:** serialized in grant order; the later grant wins in the register file. No merging or reordering.
- **Reset (asynchronous, any time):**
  - `write_en=0`, `write_addr=0`, `write_data=0`.
  - `rr_ptr=0`; counters 0.
  - An in-flight output-register write is dropped.
  - `req_ready` is forced to 0 while `reset_n=0`.

## Timing
- Grant is combinational in the same cycle as valid.
- The write appears on `write_en` in the cycle after the transfer edge (1-cycle latency).
- The register file captures it on the negedge of that cycle.
- Throughput: one write per cycle total.
- A single continuously-valid requester is granted every cycle.
- With k requesters continuously valid, each is granted exactly once every k cycles.
- `stall` takes effect in the same cycle: no transfer at that edge, and `write_en=0` in the following cycle.
- First posedge after `reset_n` rises: requester 0 has top priority.

## Configuration
- Macro `RF_WB_PERF_EN`.
- **Defined:**
  - Each `perf_stall_cnt` slice i increments by 1 on every posedge with `req_valid[i]=1 & req_ready[i]=0`.
  - Counters saturate at 2^CNT_WIDTH-1.
  - `perf_clr=1` zeroes all counters; clear has priority over increment.
- **Undefined:**
  - No counter logic is built.
  - `perf_stall_cnt` is tied to 0 and `perf_clr` is ignored.
  - Ports stay present so integration is identical.

## Test plan
- **Single requester:** after reset, `req_valid=3'b001`, addr 5, data 0xA5A5 → `req_ready=3'b001` same cycle; next cycle `write_en=1`, `write_addr=5`, `write_data=0xA5A5`; the register file reads back 0xA5A5 at address 5.
- **Fairness:** all three valid for 6 cycles with data 0x10/0x20/0x30 → grant order 0,1,2,0,1,2; `write_data` sequence 0x10,0x20,0x30,0x10,0x20,0x30.
- **Stall:**
  - Requester 1 valid and `stall=1` for 3 cycles → `req_ready=0`, `write_en=0`, `rr_ptr` unchanged.
  - Release stall → grant to requester 1 on the first cycle.
  - With `RF_WB_PERF_EN`, `perf_stall_cnt[1]=3`.
- **Same address:** requesters 0 and 2 both write addr 7 (0x11, 0x22) with `rr_ptr=0` → writes 0x11 then 0x22; final `RF[7]=0x22`.
- **Reset mid-stream:** `reset_n` low while `write_en=1` → `write_en`, `write_addr` and `write_data` go to 0 immediately (before the next clock); after release, requester 0 wins a full three-way contention.
- **Counter saturation and clear:**
  - With `CNT_WIDTH=4`, requester 2 blocked for 20 cycles → count holds at 15.
  - `perf_clr` pulse → 0 next cycle.
